// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side controller that sits in front of an async FIFO.
// A 2-entry skid buffer (entry0 is the head) decouples the producer from the
// FIFO full flag so in_ready never depends on in_valid or fifo_full.
//
// Parameters:
//   WIDTH         data width, matches the downstream async FIFO
// Ports:
//   wr_clk        write-domain clock, rising edge
//   rst           synchronous active-high reset
//   flush         synchronous discard of buffered data
//   in_valid/in_data/in_ready   producer handshake
//   fifo_full     FIFO full flag (wr_clk domain)
//   fifo_wr_er    FIFO write-error flag
//   fifo_wr_en/fifo_wr_data     FIFO write port (data is always the head entry)
//   err_sticky    latched write error, cleared by rst or flush
//   wr_count      FIFO writes performed, wraps at 16'hFFFF
//   stall_count   cycles with data buffered but FIFO full, saturates at 16'hFFFF
//
// Build option: define FIFO_WR_CTRL_STATS_EN to build the statistics counters;
// without it wr_count and stall_count are tied to zero.

module fifo_wr_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             wr_clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             fifo_full,
    input  logic             fifo_wr_er,
    output logic             fifo_wr_en,
    output logic [WIDTH-1:0] fifo_wr_data,
    output logic             err_sticky,
    output logic [15:0]      wr_count,
    output logic [15:0]      stall_count
);

    typedef enum logic [1:0] {StEmpty = 2'd0, StOne = 2'd1, StTwo = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] entry0_q, entry0_d;
    logic [WIDTH-1:0] entry1_q, entry1_d;
    logic             err_q, err_d;
    logic             push, pop;

    // Ready is decoded from state only, so there is no in_valid -> in_ready path.
    assign in_ready   = ~rst & ~flush & ((state_q == StEmpty) | (state_q == StOne));
    assign fifo_wr_en = ~rst & ~flush & ~fifo_full & (state_q != StEmpty);
    assign fifo_wr_data = entry0_q;
    assign err_sticky = err_q;

    assign push = in_valid & in_ready;
    assign pop  = fifo_wr_en;

    always_comb begin
        state_d  = state_q;
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_d  = StOne;
                        entry0_d = in_data;
                    end
                end
                StOne: begin
                    case ({push, pop})
                        // Head leaves while new data arrives: new data becomes head.
                        2'b11: entry0_d = in_data;
                        2'b10: begin
                            state_d  = StTwo;
                            entry1_d = in_data;
                        end
                        2'b01: state_d = StEmpty;
                        default: ;
                    endcase
                end
                StTwo: begin
                    // in_ready is low in TWO, so only a pop can happen here.
                    if (pop) begin
                        state_d  = StOne;
                        entry0_d = entry1_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_comb begin
        err_d = err_q;
        if (flush) begin
            err_d = 1'b0;
        end else if (fifo_wr_er) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            state_q  <= StEmpty;
            entry0_q <= '0;
            entry1_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            err_q    <= err_d;
        end
    end

`ifdef FIFO_WR_CTRL_STATS_EN
    logic [15:0] wr_count_q, wr_count_d;
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        wr_count_d    = wr_count_q;
        stall_count_d = stall_count_q;
        if (pop) begin
            wr_count_d = wr_count_q + 16'd1;
        end
        if ((state_q != StEmpty) && fifo_full && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            wr_count_q    <= 16'h0000;
            stall_count_q <= 16'h0000;
        end else begin
            wr_count_q    <= wr_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign wr_count    = wr_count_q;
    assign stall_count = stall_count_q;
`else
    assign wr_count    = 16'h0000;
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
module tb_fifo_wr_ctrl;

    logic        wr_clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_er = 1'b0;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        err_sticky;
    logic [15:0] wr_count;
    logic [15:0] stall_count;

    int checks = 0;
    int failures = 0;
    logic [7:0] wr_log[$];

    fifo_wr_ctrl #(.WIDTH(8)) dut (
        .wr_clk       (wr_clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_er   (fifo_wr_er),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .err_sticky   (err_sticky),
        .wr_count     (wr_count),
        .stall_count  (stall_count)
    );

    always #5 wr_clk = ~wr_clk;

    // Record every FIFO write; inputs only change just after the rising edge.
    always @(negedge wr_clk) begin
        if (fifo_wr_en === 1'b1) wr_log.push_back(fifo_wr_data);
    end

`ifdef FIFO_WR_CTRL_STATS_EN
    localparam bit Stats = 1'b1;
`else
    localparam bit Stats = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge, then let combinational outputs settle.
    task automatic step();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
        chk("rst_err", {31'b0, err_sticky}, 32'd0);
        chk("rst_wr_count", {16'b0, wr_count}, 32'd0);
        chk("rst_stall", {16'b0, stall_count}, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
        chk("idle_wr_en", {31'b0, fifo_wr_en}, 32'd0);

        // Streaming 0x00..0x0F
        wr_log.delete();
        in_valid = 1'b1;
        in_data  = 8'h00;
        step();
        chk("stream_first_en", {31'b0, fifo_wr_en}, 32'd1);
        chk("stream_first_data", {24'b0, fifo_wr_data}, 32'h00);
        for (int i = 1; i < 16; i++) begin
            in_data = 8'(i);
            step();
        end
        in_valid = 1'b0;
        chk("stream_last_data", {24'b0, fifo_wr_data}, 32'h0F);
        step();
        chk("stream_drained_en", {31'b0, fifo_wr_en}, 32'd0);
        #5;
        chk("stream_nwrites", wr_log.size(), 32'd16);
        for (int i = 0; i < 16 && i < wr_log.size(); i++) begin
            chk($sformatf("stream_order_%0d", i), {24'b0, wr_log[i]}, i);
        end
        chk("stream_wr_count", {16'b0, wr_count}, Stats ? 32'd16 : 32'd0);

        // Backpressure: two pushes while full fill the buffer
        do_reset();
        wr_log.delete();
        fifo_full = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA1;
        step();
        chk("bp_one_en", {31'b0, fifo_wr_en}, 32'd0);
        in_data = 8'hA2;
        step();
        in_valid = 1'b0;
        chk("bp_two_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_two_en", {31'b0, fifo_wr_en}, 32'd0);
        chk("bp_two_head", {24'b0, fifo_wr_data}, 32'hA1);
        fifo_full = 1'b0;
        #1;
        chk("bp_rel_en", {31'b0, fifo_wr_en}, 32'd1);
        step();
        chk("bp_second_data", {24'b0, fifo_wr_data}, 32'hA2);
        chk("bp_one_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk("bp_empty_en", {31'b0, fifo_wr_en}, 32'd0);
        #5;
        chk("bp_nwrites", wr_log.size(), 32'd2);
        if (wr_log.size() == 2) begin
            chk("bp_w0", {24'b0, wr_log[0]}, 32'hA1);
            chk("bp_w1", {24'b0, wr_log[1]}, 32'hA2);
        end

        // Simultaneous push/pop in ONE
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'h11;
        step();
        in_data = 8'h22;
        #1;
        chk("pp_head_en", {31'b0, fifo_wr_en}, 32'd1);
        chk("pp_head_data", {24'b0, fifo_wr_data}, 32'h11);
        step();
        in_valid = 1'b0;
        #1;
        chk("pp_next_data", {24'b0, fifo_wr_data}, 32'h22);
        chk("pp_next_en", {31'b0, fifo_wr_en}, 32'd1);
        chk("pp_next_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk("pp_empty_en", {31'b0, fifo_wr_en}, 32'd0);

        // Flush in TWO with an error latched
        do_reset();
        wr_log.delete();
        fifo_full  = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'h33;
        fifo_wr_er = 1'b1;
        step();
        fifo_wr_er = 1'b0;
        in_data    = 8'h44;
        step();
        in_valid = 1'b0;
        chk("fl_err_set", {31'b0, err_sticky}, 32'd1);
        chk("fl_two_ready", {31'b0, in_ready}, 32'd0);
        fifo_full = 1'b0;
        flush     = 1'b1;
        #1;
        chk("fl_en_blocked", {31'b0, fifo_wr_en}, 32'd0);
        chk("fl_ready_blocked", {31'b0, in_ready}, 32'd0);
        step();
        flush = 1'b0;
        #1;
        chk("fl_err_clr", {31'b0, err_sticky}, 32'd0);
        chk("fl_empty_en", {31'b0, fifo_wr_en}, 32'd0);
        chk("fl_empty_ready", {31'b0, in_ready}, 32'd1);
        step();
        step();
        chk("fl_nwrites", wr_log.size(), 32'd0);

        // Error latch, then reset asserted in TWO
        do_reset();
        fifo_wr_er = 1'b1;
        step();
        fifo_wr_er = 1'b0;
        step();
        step();
        chk("er_sticky", {31'b0, err_sticky}, 32'd1);
        fifo_full = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        step();
        in_data = 8'h66;
        step();
        in_valid = 1'b0;
        chk("er_two_ready", {31'b0, in_ready}, 32'd0);
        fifo_full = 1'b0;
        rst       = 1'b1;
        #1;
        chk("er_rst_en", {31'b0, fifo_wr_en}, 32'd0);
        step();
        chk("er_rst_err", {31'b0, err_sticky}, 32'd0);
        chk("er_rst_ready", {31'b0, in_ready}, 32'd0);
        chk("er_rst_data", {24'b0, fifo_wr_data}, 32'h00);
        rst = 1'b0;
        #1;
        chk("er_post_ready", {31'b0, in_ready}, 32'd1);
        chk("er_post_en", {31'b0, fifo_wr_en}, 32'd0);
        chk("er_post_wr_count", {16'b0, wr_count}, 32'd0);

        // Stall statistics: five full cycles in ONE
        do_reset();
        fifo_full = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("st_stall", {16'b0, stall_count}, Stats ? 32'd5 : 32'd0);
        chk("st_en_full", {31'b0, fifo_wr_en}, 32'd0);
        fifo_full = 1'b0;
        step();
        chk("st_wr_count", {16'b0, wr_count}, Stats ? 32'd1 : 32'd0);
        chk("st_stall_hold", {16'b0, stall_count}, Stats ? 32'd5 : 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, data width, equal to the downstream async FIFO WIDTH.
REQ-002 SHALL have port: wr_clk  input  1  write-domain clock; all logic on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: flush  input  1  synchronous discard of buffered data.
REQ-005 SHALL have port: in_valid  input  1  producer data valid.
REQ-006 SHALL have port: in_data  input  WIDTH  producer data.
REQ-007 SHALL have port: in_ready  output  1  controller can accept in_data this cycle.
REQ-008 SHALL have port: fifo_full  input  1  full flag from async FIFO, wr_clk domain.
REQ-009 SHALL have port: fifo_wr_er  input  1  write-error flag from async FIFO.
REQ-010 SHALL have port: fifo_wr_en  output  1  FIFO write enable.
REQ-011 SHALL have port: fifo_wr_data  output  WIDTH  FIFO write data.
REQ-012 SHALL have port: err_sticky  output  1  latched FIFO write error.
REQ-013 SHALL have port: wr_count  output  16  accepted FIFO writes (stats).
REQ-014 SHALL have port: stall_count  output  16  cycles blocked by fifo_full (stats).

Function
REQ-015 SHALL hold a 2-entry skid buffer (entry0 = head) with state machine EMPTY (0 entries), ONE (1), TWO (2).
REQ-016 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in TWO and whenever flush = 1, decoded from state only (no combinational path from in_valid).
REQ-017 SHALL define push = in_valid & in_ready and pop = fifo_wr_en.
REQ-018 SHALL drive fifo_wr_en = (state != EMPTY) & ~fifo_full & ~flush, combinationally; fifo_wr_data = entry0 at all times.
REQ-019 SHALL never assert fifo_wr_en while fifo_full = 1.
REQ-020 SHALL transition: EMPTY->ONE on push; ONE->TWO on push & ~pop; ONE->EMPTY on pop & ~push; ONE stays ONE on push & pop; TWO->ONE on pop; otherwise hold.
REQ-021 SHALL on pop shift entry1 into entry0; a simultaneous push SHALL land in the first free slot after the shift, preserving order.
REQ-022 SHALL have latency of one cycle: data accepted at edge N appears on fifo_wr_data with fifo_wr_en = 1 in cycle N+1 if fifo_full = 0.
REQ-023 SHALL sustain one write per cycle when in_valid = 1 and fifo_full = 0 continuously.
REQ-024 SHALL on flush = 1 go to EMPTY at the next edge, discarding both entries; push and pop are suppressed that cycle.
REQ-025 SHALL set err_sticky at the edge where fifo_wr_er = 1; cleared only by rst or flush.
REQ-026 SHALL give rst priority over flush, and flush priority over push/pop.

Reset
REQ-027 SHALL on rst = 1 at an edge force state EMPTY, entries 0, err_sticky 0, wr_count 0, stall_count 0.
REQ-028 SHALL during rst hold in_ready = 0 and fifo_wr_en = 0, including reset asserted mid-transfer; buffered data is lost.

Configuration
REQ-029 SHALL compile statistics counters only when macro FIFO_WR_CTRL_STATS_EN is defined.
REQ-030 SHALL with FIFO_WR_CTRL_STATS_EN: wr_count += 1 per pop, wrapping 16'hFFFF->0; stall_count += 1 per cycle with state != EMPTY & fifo_full = 1, saturating at 16'hFFFF.
REQ-031 SHALL without FIFO_WR_CTRL_STATS_EN: keep both ports, tied to 16'h0000, no counter registers.

Verification
REQ-032 SHALL cover streaming: in_valid = 1 for 16 cycles, data 0x00..0x0F, fifo_full = 0 -> 16 writes 0x00..0x0F in order, first write cycle after first accept, wr_count = 16.
REQ-033 SHALL cover backpressure: push 0xA1, 0xA2 with fifo_full = 1 -> state TWO, in_ready = 0, fifo_wr_en = 0; release full -> writes 0xA1 then 0xA2.
REQ-034 SHALL cover simultaneous push/pop in ONE: head 0x11 written while 0x22 accepted -> next cycle fifo_wr_data = 0x22, state ONE.
REQ-035 SHALL cover flush in TWO (0x33, 0x44 buffered) -> EMPTY next cycle, neither 0x33 nor 0x44 ever written, err_sticky cleared.
REQ-036 SHALL cover error latch: fifo_wr_er pulsed 1 cycle -> err_sticky = 1 until rst; rst asserted in TWO -> all outputs at reset values next cycle.
REQ-037 SHALL cover stats: fifo_full = 1 for 5 cycles with state ONE -> stall_count = 5 with FIFO_WR_CTRL_STATS_EN, 0 without.
